// File: rtl/dmem_dma_pkg.sv
// ----------------------------------------------------------------------------
// dmem_dma_pkg
// Shared types and constants for the data-memory block-copy engine.
//   dma_state_t : engine state encoding (IDLE, READ, WRITE, DONE)
//   WORD_BYTES  : byte stride between consecutive 32-bit words
//   ADDR_W      : memory byte-address width
// ----------------------------------------------------------------------------
package dmem_dma_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

endpackage : dmem_dma_pkg

// File: rtl/dmem_copy_dma.sv
// ----------------------------------------------------------------------------
// dmem_copy_dma
// Word-granular block-copy engine driving the single data-memory port
// (asynchronous read, synchronous write). Each word costs one READ cycle
// and one WRITE cycle; the port is only driven while busy.
//
// Optional build macro: DMEM_DMA_FILL_EN
//   Adds fill/pattern inputs. A fill transfer skips READ and writes the
//   latched pattern to every destination word at one word per cycle.
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   reset    in   synchronous active-high reset
//   start    in   transfer request, sampled only in IDLE
//   src      in   source byte address ([1:0] ignored)
//   dst      in   destination byte address ([1:0] ignored)
//   len      in   word count (0 = complete immediately, no access)
//   fill     in   (DMEM_DMA_FILL_EN) pattern-fill instead of copy
//   pattern  in   (DMEM_DMA_FILL_EN) fill word
//   busy     out  high in READ/WRITE
//   done     out  one-cycle completion pulse
//   mem_we   out  memory write enable (suppressed while reset is high)
//   mem_a    out  word-aligned memory byte address
//   mem_wd   out  memory write data
//   mem_rd   in   memory read data, combinational from mem_a
// ----------------------------------------------------------------------------
module dmem_copy_dma
    import dmem_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
`ifdef DMEM_DMA_FILL_EN
    input  logic              fill,
    input  logic [31:0]       pattern,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

    dma_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] src_ptr_reg, src_ptr_next;
    logic [ADDR_W-1:0] dst_ptr_reg, dst_ptr_next;
    logic [LEN_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       buf_reg, buf_next;
    logic              fill_mode;

`ifdef DMEM_DMA_FILL_EN
    logic fill_reg, fill_next;
    assign fill_mode = fill_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_reg <= 1'b0;
        end else begin
            fill_reg <= fill_next;
        end
    end
`else
    assign fill_mode = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            src_ptr_reg <= '0;
            dst_ptr_reg <= '0;
            cnt_reg     <= '0;
            buf_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            src_ptr_reg <= src_ptr_next;
            dst_ptr_reg <= dst_ptr_next;
            cnt_reg     <= cnt_next;
            buf_reg     <= buf_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        src_ptr_next = src_ptr_reg;
        dst_ptr_next = dst_ptr_reg;
        cnt_next     = cnt_reg;
        buf_next     = buf_reg;
`ifdef DMEM_DMA_FILL_EN
        fill_next    = fill_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_next = DONE;
                    end else begin
                        src_ptr_next = {src[ADDR_W-1:2], 2'b00};
                        dst_ptr_next = {dst[ADDR_W-1:2], 2'b00};
                        cnt_next     = len;
`ifdef DMEM_DMA_FILL_EN
                        fill_next    = fill;
                        if (fill) begin
                            // The pattern lives in the data buffer so WRITE
                            // needs no separate data path for fill mode.
                            buf_next   = pattern;
                            state_next = WRITE;
                        end else begin
                            state_next = READ;
                        end
`else
                        state_next   = READ;
`endif
                    end
                end
            end
            READ: begin
                buf_next   = mem_rd;
                state_next = WRITE;
            end
            WRITE: begin
                // Both pointers wrap naturally modulo 2^ADDR_W.
                src_ptr_next = src_ptr_reg + STRIDE;
                dst_ptr_next = dst_ptr_reg + STRIDE;
                cnt_next     = cnt_reg - LEN_W'(1);
                if (cnt_reg == LEN_W'(1)) begin
                    state_next = DONE;
                end else if (fill_mode) begin
                    state_next = WRITE;
                end else begin
                    state_next = READ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Port outputs decode straight from state; the write enable is gated by
    // reset so an edge that resets the engine can never also commit a word.
    assign busy   = (state_reg == READ) || (state_reg == WRITE);
    assign done   = (state_reg == DONE);
    assign mem_we = (state_reg == WRITE) && !reset;
    assign mem_a  = (state_reg == READ)  ? src_ptr_reg :
                    (state_reg == WRITE) ? dst_ptr_reg : '0;
    assign mem_wd = (state_reg == WRITE) ? buf_reg : '0;

endmodule : dmem_copy_dma

// File: doc/dmem_copy_dma.md
Name: dmem_copy_dma

Overview:
- Word-granular block-copy engine: the initiator side of the data-memory port (clk/we/a/wd/rd word interface, asynchronous read, synchronous write).
- Given source address, destination address and word count, it reads each word and writes it back to the destination through the same single port.
- Sits between the control/CSR logic and the data memory. It drives the memory port only while busy; arbitration with the core is external.

Parameters:
- LEN_W, 16, width of word-count input (max transfer 2^LEN_W-1 words)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a transfer; sampled only in IDLE
- src  input  32  source byte address; bits [1:0] ignored
- dst  input  32  destination byte address; bits [1:0] ignored
- len  input  LEN_W  number of 32-bit words to copy
- busy  output  1  high while a transfer is in progress (READ/WRITE)
- done  output  1  one-cycle pulse at transfer completion
- mem_we  output  1  memory write enable
- mem_a  output  32  memory byte address, always word-aligned ([1:0]=00)
- mem_wd  output  32  memory write data
- mem_rd  input  32  memory read data, combinational from mem_a

Behaviour:
- Clock is clk; reset is synchronous and active-high, named reset. On reset: state=IDLE, busy=0, done=0, mem_we=0, mem_a=0, mem_wd=0, all pointers/counters=0.
- mem_we is combinationally gated by !reset, so no write occurs on any edge where reset=1, including mid-transfer. A reset mid-transfer abandons the copy; words already written stay written; no done pulse.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 and len!=0: latch src_ptr={src[31:2],2'b00}, dst_ptr={dst[31:2],2'b00}, cnt=len; go to READ.
  - start=1 and len=0: go to DONE (no memory access).
  - start=0: stay in IDLE.
- READ: mem_a=src_ptr, mem_we=0; capture mem_rd into data buffer at edge; go to WRITE.
- WRITE: mem_a=dst_ptr, mem_wd=buffer, mem_we=1. At edge: src_ptr+=4, dst_ptr+=4, cnt-=1. If cnt==1 go to DONE, else go to READ.
- DONE: done=1 for exactly one cycle, busy=0; go to IDLE.
- Timing: start sampled at edge E0 gives READ word0 in cycle 1, WRITE word0 in cycle 2, WRITE word N-1 in cycle 2N, done in cycle 2N+1. Throughput is 2 cycles/word.
- busy=1 exactly in READ/WRITE. mem_a=0 and mem_wd=0 in IDLE/DONE.
- start while busy or in DONE is ignored (not queued). src/dst/len are only sampled at acceptance and may change afterwards.
- Pointers wrap modulo 2^32 (0xFFFFFFFC+4 becomes 0x00000000).
- Overlap: copy is strictly ascending. If dst is in (src, src+4·len), words are re-read after being overwritten (forward-copy smear); this is defined behaviour, not an error.
- src==dst: each word is read and rewritten unchanged.

Optional Feature:
- Macro DMEM_DMA_FILL_EN.
- When defined, adds ports fill (in, 1) and pattern (in, 32), both sampled with start.
  - If fill=1, the engine skips READ and goes IDLE to WRITE directly.
  - WRITE writes the latched pattern to dst_ptr, then loops WRITE to WRITE (1 cycle/word).
  - Completion has done in cycle N+1; src is ignored.
- When undefined, the ports are absent and behaviour is copy-only as above.

Decomposition:
- Package dmem_dma_pkg holds:
  - the state enum (IDLE, READ, WRITE, DONE)
  - WORD_BYTES=4
  - ADDR_W=32
- Single module; no sub-module. The address/counter datapath is small enough to inline.

Test Plan:
- Preload RAM[0..3]=0x11,0x22,0x33,0x44; start src=0x00, dst=0x40, len=4 → RAM[16..19] match, done pulse in cycle 9, busy high cycles 1–8, exactly 4 mem_we cycles.
- start len=0 → done in cycle 1, mem_we never asserted, RAM unchanged.
- src=0x03, dst=0x21, len=1 → mem_a=0x00 then 0x20; RAM[8]=RAM[0].
- Overlap src=0x00, dst=0x04, len=3 with RAM[0..3]=A,B,C,D → RAM[0..3]=A,A,A,A.
- Assert reset in the WRITE cycle of word 2 of a len=5 copy → no write at that edge; outputs at reset values next cycle; no done pulse; start pulse during busy is ignored.
- (DMEM_DMA_FILL_EN) fill=1, pattern=0xDEADBEEF, dst=0x80, len=3 → RAM[32..34]=0xDEADBEEF, done in cycle 4, no READ cycles.
